// File: rtl/polaris_pkg.sv
// ---------------------------------------------------------------------------
// polaris_pkg
//   Shared constants and types for the Polaris instruction-fetch unit.
//   ISIZ_*            encodings of the I-master bus size field
//   RESET_VEC_DEFAULT default first fetch address after reset
//   fetch_state_t     fetch FSM states
// ---------------------------------------------------------------------------
package polaris_pkg;

  localparam logic [1:0]  ISIZ_NONE         = 2'b00;
  localparam logic [1:0]  ISIZ_WORD         = 2'b10;
  localparam logic [63:0] RESET_VEC_DEFAULT = 64'hFFFF_FFFF_FFFF_FF00;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    STALL
  } fetch_state_t;

endpackage

// File: rtl/polaris_ifetch_if.sv
// ---------------------------------------------------------------------------
// polaris_ifetch_if
//   I-master bus between the fetch unit (master) and instruction memory (slave).
//   iadr  fetch address, zero while idle
//   isiz  2'b10 = 32-bit request active, 2'b00 = idle
//   iack  acknowledge, only meaningful while isiz != 0
//   idat  instruction word, valid with iack
// ---------------------------------------------------------------------------
interface polaris_ifetch_if #(
  parameter int AW = 64
);
  logic [AW-1:0] iadr;
  logic [1:0]    isiz;
  logic          iack;
  logic [31:0]   idat;

  modport master (output iadr, isiz, input iack, idat);
  modport slave  (input iadr, isiz, output iack, idat);
endinterface

// File: rtl/polaris_fetch_fifo.sv
// ---------------------------------------------------------------------------
// polaris_fetch_fifo
//   Synchronous FIFO with a registered head entry.
//   clk_i, reset_ni  clock / asynchronous active-low reset
//   push_i, wdata_i  write one entry (ignored while flush_i)
//   pop_i            drop the head entry (ignored when empty or flushing)
//   flush_i          empty the FIFO; wins over push and pop
//   valid_o, head_o  head entry and its valid flag, both straight from flops
//   count_o          number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module polaris_fetch_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         push_i,
  input  logic [W-1:0]                 wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         valid_o,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q;
  logic          do_push, do_pop;

  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; that is what keeps this from inferring a latch.
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && valid_q && !flush_i;
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    head_d   = head_q;
    // The next head is either already stored, or is the word being written
    // right now into an otherwise empty queue.
    if (count_d != '0) begin
      head_d = (do_push && (rd_ptr_d == wr_ptr_q)) ? wdata_i : mem[rd_ptr_d];
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, so clearing it would only cost reset routing.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_q + PW'(do_push);
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      head_q   <= head_d;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign count_o = count_q;

  // The fetch FSM stops requesting before the queue can overflow.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(push_i && !flush_i && !(pop_i && valid_q) && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/polaris_ifetch.sv
// ---------------------------------------------------------------------------
// polaris_ifetch
//   Instruction-fetch unit with a DEPTH-entry prefetch queue.
//   clk_i, reset_ni          clock / asynchronous active-low reset
//   ibus (master)            I-master bus: iadr, isiz out; iack, idat in
//   ir_valid_o, ir_o, ir_pc_o  queue head word and its address
//   ir_ready_i               consumer pops the head when ir_valid_o is high
//   redirect_i, redirect_pc_i  flush the queue and restart fetch (word aligned)
//   busy_o                   request outstanding or a stale response pending
// ---------------------------------------------------------------------------
module polaris_ifetch
  import polaris_pkg::*;
#(
  parameter int          AW        = 64,
  parameter int          DEPTH     = 4,
  parameter logic [63:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  polaris_ifetch_if.master ibus,
  output logic            ir_valid_o,
  output logic [31:0]     ir_o,
  output logic [AW-1:0]   ir_pc_o,
  input  logic            ir_ready_i,
  input  logic            redirect_i,
  input  logic [AW-1:0]   redirect_pc_i,
  output logic            busy_o
);

  localparam int W  = AW + 32;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state_q;
  logic [AW-1:0] fpc_q, fpc_d, iadr_q, redirect_pc;
  logic [1:0]    isiz_q;
  logic          discard_q;
  logic          ack, push, pop_fire, will_fill;
  logic [CW-1:0] fifo_count;
  logic [W-1:0]  fifo_head;

  assign redirect_pc = redirect_pc_i & ~AW'(3);
  assign ack         = (state_q == FETCH) && ibus.iack;
  // A redirect or a pending discard turns the acked word into a drop.
  assign push        = ack && !discard_q && !redirect_i;
  assign pop_fire    = ir_valid_o && ir_ready_i;
  assign will_fill   = push && !pop_fire && (fifo_count == CW'(DEPTH - 1));

  // fpc is the next address to request; after a discarded request it already
  // holds the redirect target, so the stale ack must not advance it.
  always_comb begin
    fpc_d = fpc_q;
    if (redirect_i)              fpc_d = redirect_pc;
    else if (ack && !discard_q)  fpc_d = fpc_q + AW'(4);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= BOOT;
      fpc_q     <= RESET_VEC[AW-1:0];
      discard_q <= 1'b0;
      isiz_q    <= ISIZ_NONE;
      iadr_q    <= '0;
    end else begin
      fpc_q <= fpc_d;
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          isiz_q  <= ISIZ_WORD;
          iadr_q  <= fpc_d;
        end
        FETCH: begin
          if (ibus.iack) begin
            discard_q <= 1'b0;
            if (will_fill) begin
              state_q <= STALL;
              isiz_q  <= ISIZ_NONE;
              iadr_q  <= '0;
            end else begin
              iadr_q  <= fpc_d;
            end
          end else if (redirect_i) begin
            // The bus request cannot be withdrawn; let it finish and drop it.
            discard_q <= 1'b1;
          end
        end
        STALL: begin
          if (redirect_i || (fifo_count < CW'(DEPTH))) begin
            state_q <= FETCH;
            isiz_q  <= ISIZ_WORD;
            iadr_q  <= fpc_d;
          end
        end
        default: begin
          state_q <= BOOT;
          isiz_q  <= ISIZ_NONE;
          iadr_q  <= '0;
        end
      endcase
    end
  end

  polaris_fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (push),
    .wdata_i  ({iadr_q, ibus.idat}),
    .pop_i    (ir_ready_i),
    .flush_i  (redirect_i),
    .valid_o  (ir_valid_o),
    .head_o   (fifo_head),
    .count_o  (fifo_count)
  );

  assign ibus.iadr = iadr_q;
  assign ibus.isiz = isiz_q;
  assign ir_o      = fifo_head[31:0];
  assign ir_pc_o   = fifo_head[W-1:32];
  assign busy_o    = (isiz_q != ISIZ_NONE) || discard_q;

endmodule

// File: tb/tb_polaris_ifetch.sv
// ---------------------------------------------------------------------------
// tb_polaris_ifetch
//   Directed bench for polaris_ifetch: a 64-bit / DEPTH=4 instance for the
//   main scenarios and a 32-bit / DEPTH=2 instance for wrap and reset cases.
// ---------------------------------------------------------------------------
module tb_polaris_ifetch;
  import polaris_pkg::*;

  localparam logic [63:0] RV64 = 64'hFFFF_FFFF_FFFF_FF00;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  polaris_ifetch_if #(.AW(64)) bus ();
  logic        ir_valid, ir_ready, redirect, busy;
  logic [31:0] ir;
  logic [63:0] ir_pc, redirect_pc;

  polaris_ifetch #(.AW(64), .DEPTH(4)) dut (
    .clk_i(clk), .reset_ni(reset_n), .ibus(bus),
    .ir_valid_o(ir_valid), .ir_o(ir), .ir_pc_o(ir_pc), .ir_ready_i(ir_ready),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .busy_o(busy)
  );

  polaris_ifetch_if #(.AW(32)) bus32 ();
  logic        ir_valid32, ir_ready32, redirect32, busy32;
  logic [31:0] ir32, ir_pc32, redirect_pc32;

  polaris_ifetch #(.AW(32), .DEPTH(2)) dut32 (
    .clk_i(clk), .reset_ni(reset_n), .ibus(bus32),
    .ir_valid_o(ir_valid32), .ir_o(ir32), .ir_pc_o(ir_pc32), .ir_ready_i(ir_ready32),
    .redirect_i(redirect32), .redirect_pc_i(redirect_pc32), .busy_o(busy32)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] exp_word(input logic [63:0] pc);
    return {pc[7:0], 24'h000013};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.iack = 1'b0; bus.idat = '0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus32.iack = 1'b0; bus32.idat = '0; ir_ready32 = 1'b0; redirect32 = 1'b0; redirect_pc32 = '0;
    reset_n = 1'b0;
    step; step;
    n_checks++; if (bus.isiz !== ISIZ_NONE) begin n_fail++; $display("FAIL rst_isiz: got %b want %b", bus.isiz, ISIZ_NONE); end
    n_checks++; if (bus.iadr !== 64'h0) begin n_fail++; $display("FAIL rst_iadr: got %h want 0", bus.iadr); end
    n_checks++; if ({ir_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_valid_busy: got %b want 00", {ir_valid, busy}); end
    reset_n = 1'b1;
    #2;
    n_checks++; if (bus.isiz !== ISIZ_NONE) begin n_fail++; $display("FAIL boot_isiz: got %b want %b", bus.isiz, ISIZ_NONE); end
    step;
    n_checks++; if ({bus.isiz, bus.iadr} !== {ISIZ_WORD, RV64}) begin n_fail++; $display("FAIL first_req: got %b/%h want %b/%h", bus.isiz, bus.iadr, ISIZ_WORD, RV64); end
    for (int i = 0; i < 3; i++) begin
      step;
      n_checks++; if ({bus.isiz, bus.iadr, busy} !== {ISIZ_WORD, RV64, 1'b1}) begin n_fail++; $display("FAIL req_hold: got %b/%h busy=%b", bus.isiz, bus.iadr, busy); end
    end
  endtask

  task automatic test_fill_stall;
    logic [63:0] pc;
    bit found;
    ir_ready = 1'b0;
    bus.iack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = RV64 + 64'(4 * i);
      bus.idat = exp_word(pc);
      n_checks++; if ({bus.isiz, bus.iadr} !== {ISIZ_WORD, pc}) begin n_fail++; $display("FAIL fill_req: got %b/%h want %h", bus.isiz, bus.iadr, pc); end
      step;
    end
    n_checks++; if ({bus.isiz, bus.iadr} !== {ISIZ_NONE, 64'h0}) begin n_fail++; $display("FAIL stall_bus: got %b/%h want 00/0", bus.isiz, bus.iadr); end
    n_checks++; if ({ir_valid, ir_pc, ir} !== {1'b1, RV64, exp_word(RV64)}) begin n_fail++; $display("FAIL stall_head: got %b/%h/%h want 1/%h", ir_valid, ir_pc, ir, RV64); end
    step;
    n_checks++; if (bus.isiz !== ISIZ_NONE) begin n_fail++; $display("FAIL stall_hold: got %b want 00", bus.isiz); end
    ir_ready = 1'b1;
    step;
    ir_ready = 1'b0;
    n_checks++; if (ir_pc !== RV64 + 64'h4) begin n_fail++; $display("FAIL pop_head: got %h want %h", ir_pc, RV64 + 64'h4); end
    bus.idat = exp_word(RV64 + 64'h10);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (bus.isiz === ISIZ_WORD) found = 1'b1;
      else step;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL refetch_timeout: got isiz=%b want 10 within 4 cycles", bus.isiz); end
    n_checks++; if (bus.iadr !== RV64 + 64'h10) begin n_fail++; $display("FAIL refetch_adr: got %h want %h", bus.iadr, RV64 + 64'h10); end
    step;
    n_checks++; if (bus.isiz !== ISIZ_NONE) begin n_fail++; $display("FAIL refill_stall: got %b want 00", bus.isiz); end
  endtask

  task automatic test_stream;
    logic [63:0] pc;
    bus.iack = 1'b0;
    ir_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      pc = RV64 + 64'h4 + 64'(4 * j);
      n_checks++; if ({ir_valid, ir_pc, ir} !== {1'b1, pc, exp_word(pc)}) begin n_fail++; $display("FAIL drain: got %b/%h/%h want 1/%h/%h", ir_valid, ir_pc, ir, pc, exp_word(pc)); end
      step;
    end
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b want 0", ir_valid); end
    n_checks++; if ({bus.isiz, bus.iadr} !== {ISIZ_WORD, RV64 + 64'h14}) begin n_fail++; $display("FAIL drained_req: got %b/%h want 10/%h", bus.isiz, bus.iadr, RV64 + 64'h14); end
    bus.iack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pc = RV64 + 64'h14 + 64'(4 * k);
      n_checks++; if ({bus.isiz, bus.iadr} !== {ISIZ_WORD, pc}) begin n_fail++; $display("FAIL stream_req: got %b/%h want 10/%h", bus.isiz, bus.iadr, pc); end
      if (k == 0) begin
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid: got %b want 0", ir_valid); end
      end else begin
        n_checks++; if ({ir_valid, ir_pc, ir} !== {1'b1, pc - 64'h4, exp_word(pc - 64'h4)}) begin n_fail++; $display("FAIL stream_head: got %b/%h/%h want 1/%h", ir_valid, ir_pc, ir, pc - 64'h4); end
      end
      bus.idat = exp_word(pc);
      step;
    end
    bus.iack = 1'b0;
    n_checks++; if ({ir_valid, ir_pc, bus.iadr} !== {1'b1, RV64 + 64'h28, RV64 + 64'h2C}) begin n_fail++; $display("FAIL stream_tail: got %b/%h/%h", ir_valid, ir_pc, bus.iadr); end
    step;
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b want 0", ir_valid); end
    ir_ready = 1'b0;
  endtask

  task automatic test_redirect_inflight;
    redirect = 1'b1; redirect_pc = 64'h127;
    step;
    redirect = 1'b0;
    n_checks++; if ({bus.isiz, bus.iadr, busy, ir_valid} !== {ISIZ_WORD, RV64 + 64'h2C, 1'b1, 1'b0}) begin n_fail++; $display("FAIL rd_hold: got %b/%h busy=%b v=%b", bus.isiz, bus.iadr, busy, ir_valid); end
    step;
    n_checks++; if (bus.iadr !== RV64 + 64'h2C) begin n_fail++; $display("FAIL rd_hold2: got %h want %h", bus.iadr, RV64 + 64'h2C); end
    bus.iack = 1'b1; bus.idat = 32'hDEAD_BEEF;
    step;
    bus.iack = 1'b0;
    n_checks++; if ({bus.isiz, bus.iadr} !== {ISIZ_WORD, 64'h124}) begin n_fail++; $display("FAIL rd_newreq: got %b/%h want 10/124", bus.isiz, bus.iadr); end
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rd_dropped: got valid=%b pc=%h want 0", ir_valid, ir_pc); end
    bus.iack = 1'b1; bus.idat = exp_word(64'h124);
    step;
    bus.iack = 1'b0;
    n_checks++; if ({ir_valid, ir_pc, ir, bus.iadr} !== {1'b1, 64'h124, exp_word(64'h124), 64'h128}) begin n_fail++; $display("FAIL rd_first: got %b/%h/%h/%h", ir_valid, ir_pc, ir, bus.iadr); end
  endtask

  task automatic test_redirect_ack_pop;
    bus.iack = 1'b1; bus.idat = 32'hBAD0_0001; ir_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'h2000_0001;
    step;
    bus.iack = 1'b0; ir_ready = 1'b0; redirect = 1'b0;
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rap_flush: got valid=%b pc=%h want 0", ir_valid, ir_pc); end
    n_checks++; if ({bus.isiz, bus.iadr} !== {ISIZ_WORD, 64'h2000_0000}) begin n_fail++; $display("FAIL rap_req: got %b/%h want 10/20000000", bus.isiz, bus.iadr); end
    step;
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rap_nodata: got valid=%b want 0", ir_valid); end
    bus.iack = 1'b1; bus.idat = exp_word(64'h2000_0000);
    step;
    bus.iack = 1'b0;
    n_checks++; if ({ir_valid, ir_pc, ir} !== {1'b1, 64'h2000_0000, exp_word(64'h2000_0000)}) begin n_fail++; $display("FAIL rap_first: got %b/%h/%h", ir_valid, ir_pc, ir); end
  endtask

  task automatic test_redirect_stall;
    bit found;
    bus.iack = 1'b1; bus.idat = 32'h0000_0013;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step;
      if (bus.isiz === ISIZ_NONE) found = 1'b1;
    end
    bus.iack = 1'b0;
    n_checks++; if (!found) begin n_fail++; $display("FAIL rs_fill_timeout: got isiz=%b want 00 within 8 cycles", bus.isiz); end
    n_checks++; if ({ir_valid, ir_pc} !== {1'b1, 64'h2000_0000}) begin n_fail++; $display("FAIL rs_head: got %b/%h", ir_valid, ir_pc); end
    redirect = 1'b1; redirect_pc = 64'h300;
    step;
    redirect = 1'b0;
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rs_flush: got %b want 0", ir_valid); end
    n_checks++; if ({bus.isiz, bus.iadr, busy} !== {ISIZ_WORD, 64'h300, 1'b1}) begin n_fail++; $display("FAIL rs_req: got %b/%h busy=%b", bus.isiz, bus.iadr, busy); end
  endtask

  task automatic test_double_redirect;
    redirect = 1'b1; redirect_pc = 64'h400;
    step;
    redirect_pc = 64'h500;
    step;
    redirect = 1'b0;
    n_checks++; if ({bus.isiz, bus.iadr, busy} !== {ISIZ_WORD, 64'h300, 1'b1}) begin n_fail++; $display("FAIL dr_hold: got %b/%h busy=%b", bus.isiz, bus.iadr, busy); end
    bus.iack = 1'b1; bus.idat = 32'hBAD0_0002;
    step;
    bus.iack = 1'b0;
    n_checks++; if ({bus.isiz, bus.iadr, ir_valid} !== {ISIZ_WORD, 64'h500, 1'b0}) begin n_fail++; $display("FAIL dr_newreq: got %b/%h v=%b want 10/500/0", bus.isiz, bus.iadr, ir_valid); end
  endtask

  task automatic test_wrap_reset32;
    bit found;
    reset_n = 1'b0;
    step; step;
    reset_n = 1'b1;
    redirect32 = 1'b1; redirect_pc32 = 32'hFFFF_FFFC;
    step;
    redirect32 = 1'b0;
    n_checks++; if ({bus32.isiz, bus32.iadr} !== {ISIZ_WORD, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL w_boot_redirect: got %b/%h", bus32.isiz, bus32.iadr); end
    bus32.iack = 1'b1; bus32.idat = 32'h1111_0013;
    step;
    n_checks++; if ({bus32.isiz, bus32.iadr} !== {ISIZ_WORD, 32'h0}) begin n_fail++; $display("FAIL w_wrap: got %b/%h want 10/00000000", bus32.isiz, bus32.iadr); end
    n_checks++; if ({ir_valid32, ir_pc32, ir32} !== {1'b1, 32'hFFFF_FFFC, 32'h1111_0013}) begin n_fail++; $display("FAIL w_head: got %b/%h/%h", ir_valid32, ir_pc32, ir32); end
    bus32.idat = 32'h2222_0013;
    step;
    bus32.iack = 1'b0;
    n_checks++; if (bus32.isiz !== ISIZ_NONE) begin n_fail++; $display("FAIL w_full2: got %b want 00", bus32.isiz); end
    ir_ready32 = 1'b1;
    step;
    ir_ready32 = 1'b0;
    n_checks++; if ({ir_pc32, ir32} !== {32'h0, 32'h2222_0013}) begin n_fail++; $display("FAIL w_pop: got %h/%h", ir_pc32, ir32); end
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (bus32.isiz === ISIZ_WORD) found = 1'b1;
      else step;
    end
    n_checks++; if (!found || bus32.iadr !== 32'h4) begin n_fail++; $display("FAIL w_refetch: got isiz=%b iadr=%h want 10/4", bus32.isiz, bus32.iadr); end
    redirect32 = 1'b1; redirect_pc32 = 32'h40;
    step;
    redirect32 = 1'b0;
    n_checks++; if ({busy32, bus32.iadr} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL w_discard: got busy=%b iadr=%h", busy32, bus32.iadr); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({bus32.isiz, bus32.iadr} !== {ISIZ_NONE, 32'h0}) begin n_fail++; $display("FAIL ar_bus: got %b/%h want 00/0", bus32.isiz, bus32.iadr); end
    n_checks++; if ({ir_valid32, ir32, ir_pc32, busy32} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin n_fail++; $display("FAIL ar_outs: got %b/%h/%h/%b", ir_valid32, ir32, ir_pc32, busy32); end
    n_checks++; if ({bus.isiz, busy, ir_valid} !== {ISIZ_NONE, 1'b0, 1'b0}) begin n_fail++; $display("FAIL ar_dut64: got %b/%b/%b", bus.isiz, busy, ir_valid); end
    step; step;
    reset_n = 1'b1;
    step;
    n_checks++; if ({bus32.isiz, bus32.iadr} !== {ISIZ_WORD, 32'hFFFF_FF00}) begin n_fail++; $display("FAIL ar_restart: got %b/%h", bus32.isiz, bus32.iadr); end
    bus32.iack = 1'b1; bus32.idat = 32'h3333_0013;
    step;
    bus32.iack = 1'b0;
    n_checks++; if ({ir_valid32, ir_pc32, ir32} !== {1'b1, 32'hFFFF_FF00, 32'h3333_0013}) begin n_fail++; $display("FAIL ar_no_discard: got %b/%h/%h", ir_valid32, ir_pc32, ir32); end
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_stream();
    test_redirect_inflight();
    test_redirect_ack_pop();
    test_redirect_stall();
    test_double_redirect();
    test_wrap_reset32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
